// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: digit sequencing with guard band,
// leading-zero blanking and frame-aligned (tear-free) commits of a shadowed value.
module seg7_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int GUARD_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  hex,
    output logic        dp_n,
    output logic [3:0]  anodes,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int MAX_CYC = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_d;
    logic               commit;

    logic [15:0]        shadow_val, disp_val, disp_val_d;
    logic [3:0]         shadow_dp, disp_dp, disp_dp_d;
    logic               pending;

    logic [15:0]        upper;
    logic               blank;
    logic [3:0]         hex_d, anodes_d;
    logic               dp_n_d;

    // Next-state sequencing; enable low wins from any state.
    always_comb begin
        state_d = state_q;
        idx_d   = digit_idx;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!enable) begin
            state_d = ST_OFF;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_GUARD;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
                ST_GUARD: begin
                    if (cnt_q == CNT_W'(GUARD_CYC - 1)) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                        idx_d   = digit_idx + 2'd1;
                        commit  = (digit_idx == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the post-edge view so all three land on one edge.
    always_comb begin
        disp_val_d = (commit && pending) ? shadow_val : disp_val;
        disp_dp_d  = (commit && pending) ? shadow_dp  : disp_dp;
        upper      = disp_val_d >> {idx_d, 2'b00};
        blank      = lz_en && (idx_d != 2'd0) && (upper == 16'd0);
        hex_d      = 4'd0;
        dp_n_d     = 1'b1;
        anodes_d   = 4'b1111;
        if (state_d != ST_OFF) begin
            hex_d  = upper[3:0];
            dp_n_d = !(disp_dp_d[idx_d] && !blank);
        end
        if (state_d == ST_DRIVE && !blank) begin
            anodes_d = ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            digit_idx  <= 2'd0;
            frame_done <= 1'b0;
            shadow_val <= 16'd0;
            shadow_dp  <= 4'd0;
            disp_val   <= 16'd0;
            disp_dp    <= 4'd0;
            pending    <= 1'b0;
            hex        <= 4'd0;
            dp_n       <= 1'b1;
            anodes     <= 4'b1111;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_idx  <= idx_d;
            frame_done <= commit;
            disp_val   <= disp_val_d;
            disp_dp    <= disp_dp_d;
            hex        <= hex_d;
            dp_n       <= dp_n_d;
            anodes     <= anodes_d;
            // A load coinciding with a commit keeps pending set for the next frame.
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position model checked every cycle plus directed
// literal checks on scan order, tear-free loads, blanking, disable and async reset.
module tb_seg7_scan_ctrl;

    localparam int D = 4;
    localparam int G = 2;
    localparam int P = G + D;
    localparam int F = 4 * P;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'd0;
    logic [3:0]  dp_in = 4'd0;
    logic        lz_en = 1'b0;
    logic [3:0]  hex;
    logic        dp_n;
    logic [3:0]  anodes;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    seg7_scan_ctrl #(.CLK_DIV(D), .GUARD_CYC(G)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .lz_en(lz_en), .hex(hex), .dp_n(dp_n), .anodes(anodes),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position inside the enabled run decides everything.
    bit          m_run = 1'b0;
    int          m_k = 0;
    logic [15:0] m_shadow = 16'd0, m_disp = 16'd0;
    logic [3:0]  m_sdp = 4'd0, m_ddp = 4'd0;
    logic [3:0]  e_hex = 4'd0, e_an = 4'hf;
    logic        e_dpn = 1'b1, e_fd = 1'b0;
    logic [1:0]  e_idx = 2'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0; m_k = 0;
            m_shadow = 16'd0; m_sdp = 4'd0; m_disp = 16'd0; m_ddp = 4'd0;
        end else begin
            if (!enable) begin
                m_run = 1'b0; m_k = 0;
            end else begin
                if (!m_run) begin m_run = 1'b1; m_k = 0; end
                else m_k++;
                if (m_k % F == 0) begin m_disp = m_shadow; m_ddp = m_sdp; end
            end
            if (load) begin m_shadow = value; m_sdp = dp_in; end
        end
        if (!m_run) begin
            e_hex = 4'd0; e_dpn = 1'b1; e_an = 4'hf; e_idx = 2'd0; e_fd = 1'b0;
        end else begin
            int digit;
            bit blank;
            digit = (m_k / P) % 4;
            blank = (reset_n && lz_en) && digit != 0 && ((m_disp >> (4 * digit)) == 16'd0);
            e_idx = 2'(digit);
            e_hex = 4'((m_disp >> (4 * digit)) & 16'hf);
            e_dpn = !(m_ddp[digit] && !blank);
            e_an  = ((m_k % P) >= G && !blank) ? ~(4'b0001 << digit) : 4'hf;
            e_fd  = (m_k % F == 0);
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_on) begin
            check("model_hex", hex, e_hex);
            check("model_dp_n", dp_n, e_dpn);
            check("model_anodes", anodes, e_an);
            check("model_digit_idx", digit_idx, e_idx);
            check("model_frame_done", frame_done, e_fd);
        end
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        load = 1'b1; value = v; dp_in = dp;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        n_chk++; n_fail++;
        $display("FAIL wait_fd: no frame_done within 200 cycles");
    endtask

    logic [3:0] an_tab [0:25];
    int bad;

    initial begin
        an_tab = '{4'hf, 4'hf, 4'he, 4'he, 4'he, 4'he,
                   4'hf, 4'hf, 4'hd, 4'hd, 4'hd, 4'hd,
                   4'hf, 4'hf, 4'hb, 4'hb, 4'hb, 4'hb,
                   4'hf, 4'hf, 4'h7, 4'h7, 4'h7, 4'h7,
                   4'hf, 4'hf};
        repeat (3) @(negedge clk);
        check("reset_anodes", anodes, 4'hf);
        check("reset_hex", hex, 4'h0);
        check("reset_dp_n", dp_n, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);

        // 1: scan order and frame period
        reset_n = 1'b1; enable = 1'b1; chk_on = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            check("scan_anodes", anodes, an_tab[c]);
            check("scan_fd", frame_done, (c == 0 || c == 24) ? 1'b1 : 1'b0);
        end

        // 2: load mid-frame is held until the next frame start
        do_load(16'h1A3F, 4'b0101);
        check("no_tear_hex", hex, 4'h0);
        wait_fd();
        skip(2);  check("d0_hex", hex, 4'hF); check("d0_dp_n", dp_n, 1'b0);
        skip(6);  check("d1_hex", hex, 4'h3); check("d1_an", anodes, 4'hd);
        skip(6);  check("d2_hex", hex, 4'hA);
        skip(6);  check("d3_hex", hex, 4'h1); check("d3_an", anodes, 4'h7);

        // 3: leading-zero blanking
        lz_en = 1'b1;
        do_load(16'h0050, 4'b1111);
        wait_fd();
        bad = 0;
        for (int c = 0; c < F; c++) begin
            if (anodes == 4'h7 || anodes == 4'hb) bad++;
            if (c == 2)  begin check("lz_d0_hex", hex, 4'h0); check("lz_d0_an", anodes, 4'he); end
            if (c == 8)  begin check("lz_d1_hex", hex, 4'h5); check("lz_d1_dp_n", dp_n, 1'b0); end
            if (c == 14) check("lz_d2_dp_n", dp_n, 1'b1);
            @(negedge clk);
        end
        check("lz_blanked_count", 16'(bad), 16'd0);
        do_load(16'h0000, 4'b0000);
        wait_fd();
        bad = 0;
        for (int c = 0; c < F; c++) begin
            if (anodes != 4'hf && anodes != 4'he) bad++;
            @(negedge clk);
        end
        check("lz_zero_count", 16'(bad), 16'd0);
        lz_en = 1'b0;

        // 4: last load wins; load on the commit edge goes to the following frame
        wait_fd();
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        skip(F - 3);
        do_load(16'h3333, 4'b1000);
        check("ll_fd", frame_done, 1'b1);
        skip(2);  check("ll_hex_2222", hex, 4'h2);
        skip(F);  check("ll_hex_3333", hex, 4'h3);

        // 5: disable during digit 2 drive, then re-enable
        wait_fd();
        skip(14);
        check("dis_pre_an", anodes, 4'hb);
        enable = 1'b0;
        @(negedge clk);
        check("dis_an", anodes, 4'hf);
        check("dis_idx", digit_idx, 2'd0);
        skip(3);
        enable = 1'b1;
        @(negedge clk);
        check("reen_fd", frame_done, 1'b1);
        check("reen_idx", digit_idx, 2'd0);
        check("reen_an", anodes, 4'hf);
        skip(2);
        check("reen_d0_an", anodes, 4'he);

        // 6: asynchronous reset mid-drive
        #2 reset_n = 1'b0;
        #1;
        check("areset_anodes", anodes, 4'hf);
        check("areset_hex", hex, 4'h0);
        check("areset_dp_n", dp_n, 1'b1);
        check("areset_idx", digit_idx, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_fd", frame_done, 1'b1);
        skip(2);
        check("post_reset_hex", hex, 4'h0);
        skip(F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
